rr_stream_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit streaming multiplexer: the registered, handshaked successor of the 2:1 combinational mux. Arbitrates among N valid/ready input channels, round-robin or fixed-priority, and forwards the winner through a one-stage output register. Optional packet locking keeps a channel granted until its last beat. Sits between multiple producers and a single shared consumer: bus port, FIFO, or serializer.

---
 rtl/rr_stream_mux_pkg.sv | 8 +
 rtl/rr_stream_mux_arbiter.sv | 34 +++
 rtl/rr_stream_mux.sv | 77 +++++++
 tb/tb_rr_stream_mux.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// mux_pkg: mode encodings and select-width helper shared by the stream mux
package mux_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: round-robin or fixed-priority grant with packet lock override
module rr_arbiter import mux_pkg::*; #(
  parameter int N = 4,
  parameter int MODE = MODE_RR,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);
  logic             hit;
  logic [SEL_W-1:0] cand;
  // scan from the far end so the candidate nearest the start point wins; lock overrides
  always_comb begin
    idx = '0;
    hit = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = SEL_W'((MODE == MODE_FIXED) ? k : (int'(ptr) + k) % N);
      if (req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
    if (lock) begin
      idx = lock_idx;
      hit = req[lock_idx];
    end
    grant = hit ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready arbiter feeding a one-stage output register
module rr_stream_mux import mux_pkg::*; #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int MODE = MODE_RR,
  parameter int PACKET = 0,
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_last,
  input  logic               out_ready
);
  logic             can_load, acc, beat_last;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] idx, idx_inc;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d, ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;

  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req(in_valid), .ptr(ptr_q), .lock(lock_q), .lock_idx(lock_idx_q),
    .grant(grant), .idx(idx)
  );

  // readiness is held low during reset so no beat is offered while state is clearing
  assign can_load  = !out_valid_q || out_ready;
  assign in_ready  = (rst_n && can_load) ? grant : '0;
  assign acc       = |in_ready;
  assign beat_last = in_last[idx];
  assign idx_inc   = (idx == SEL_W'(N - 1)) ? '0 : idx + 1'b1;

  // next-state for output register, rr pointer and packet lock
  always_comb begin
    out_valid_d = acc ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = acc ? in_data[idx*WIDTH +: WIDTH] : out_data_q;
    out_sel_d   = acc ? idx : out_sel_q;
    out_last_d  = acc ? beat_last : out_last_q;
    ptr_d       = (acc && (PACKET == 0 || beat_last)) ? idx_inc : ptr_q;
    lock_d      = (acc && PACKET != 0) ? !beat_last : lock_q;
    lock_idx_d  = acc ? idx : lock_idx_q;
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: scoreboard bench over round-robin, fixed-priority and packet instances
module tb_rr_stream_mux;
  logic clk, rst_n;
  logic [3:0]  rr_iv, rr_il, rr_ird, fx_iv, fx_il, fx_ird, pk_iv, pk_il, pk_ird;
  logic [31:0] rr_id, fx_id, pk_id;
  logic        rr_ov, rr_ol, rr_ordy, fx_ov, fx_ol, fx_ordy, pk_ov, pk_ol, pk_ordy;
  logic [7:0]  rr_od, fx_od, pk_od;
  logic [1:0]  rr_os, fx_os, pk_os;
  logic [10:0] q_rr[$], q_fx[$], q_pk[$];
  int          n_run = 0, n_fail = 0, rr_cnt = 0, c0;

  rr_stream_mux #(.N(4), .WIDTH(8), .MODE(0), .PACKET(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_iv), .in_data(rr_id), .in_last(rr_il),
    .in_ready(rr_ird), .out_valid(rr_ov), .out_data(rr_od), .out_sel(rr_os),
    .out_last(rr_ol), .out_ready(rr_ordy));
  rr_stream_mux #(.N(4), .WIDTH(8), .MODE(1), .PACKET(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(fx_iv), .in_data(fx_id), .in_last(fx_il),
    .in_ready(fx_ird), .out_valid(fx_ov), .out_data(fx_od), .out_sel(fx_os),
    .out_last(fx_ol), .out_ready(fx_ordy));
  rr_stream_mux #(.N(4), .WIDTH(8), .MODE(0), .PACKET(1)) u_pk (
    .clk(clk), .rst_n(rst_n), .in_valid(pk_iv), .in_data(pk_id), .in_last(pk_il),
    .in_ready(pk_ird), .out_valid(pk_ov), .out_data(pk_od), .out_sel(pk_os),
    .out_last(pk_ol), .out_ready(pk_ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] beat(input logic [1:0] s, input logic l, input logic [7:0] d);
    return {s, l, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && rr_ov && rr_ordy) begin
      rr_cnt++;
      if (q_rr.size() == 0) check("rr_spurious", 32'(q_rr.size()), 32'd1);
      else check("rr_beat", 32'({rr_os, rr_ol, rr_od}), 32'(q_rr.pop_front()));
    end

  always @(negedge clk)
    if (rst_n && fx_ov && fx_ordy) begin
      if (q_fx.size() == 0) check("fx_spurious", 32'(q_fx.size()), 32'd1);
      else check("fx_beat", 32'({fx_os, fx_ol, fx_od}), 32'(q_fx.pop_front()));
    end

  always @(negedge clk)
    if (rst_n && pk_ov && pk_ordy) begin
      if (q_pk.size() == 0) check("pk_spurious", 32'(q_pk.size()), 32'd1);
      else check("pk_beat", 32'({pk_os, pk_ol, pk_od}), 32'(q_pk.pop_front()));
    end

  initial begin
    rst_n = 1'b0;
    rr_iv = '0; fx_iv = '0; pk_iv = '0;
    rr_il = '0; fx_il = '0; pk_il = '0;
    rr_id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    fx_id = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    pk_id = '0;
    rr_ordy = 1'b1; fx_ordy = 1'b1; pk_ordy = 1'b1;
    repeat (2) tick();
    check("rst_valid", 32'(rr_ov), 32'd0);
    check("rst_sel", 32'(rr_os), 32'd0);
    check("rst_data", 32'(rr_od), 32'd0);
    check("rst_pk_valid", 32'(pk_ov), 32'd0);
    rst_n = 1'b1;
    // reset asserted mid-transfer
    rr_iv = 4'hF;
    q_rr.push_back(beat(2'd0, 1'b0, 8'hA0));
    q_rr.push_back(beat(2'd1, 1'b0, 8'hA1));
    tick();
    tick();
    check("pre_rst_data", 32'(rr_od), 32'hA1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rr_ov), 32'd0);
    check("async_rst_sel", 32'(rr_os), 32'd0);
    check("async_rst_data", 32'(rr_od), 32'd0);
    check("async_rst_ready", 32'(rr_ird), 32'd0);
    q_rr.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(rr_ird), 32'h1);
    // round-robin, all channels valid
    c0 = rr_cnt;
    for (int k = 0; k < 10; k++) q_rr.push_back(beat(2'(k % 4), 1'b0, 8'(8'hA0 + k % 4)));
    repeat (10) tick();
    rr_iv = '0;
    @(negedge clk);
    #1;
    check("rr_throughput", 32'(rr_cnt - c0), 32'd10);
    tick();
    check("rr_idle_valid", 32'(rr_ov), 32'd0);
    check("rr_q_empty", 32'(q_rr.size()), 32'd0);
    // backpressure then same-cycle reload
    rr_ordy = 1'b0;
    rr_id[7:0] = 8'h55;
    rr_id[23:16] = 8'h77;
    rr_iv = 4'b0001;
    q_rr.push_back(beat(2'd0, 1'b0, 8'h55));
    q_rr.push_back(beat(2'd2, 1'b0, 8'h77));
    tick();
    rr_iv = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(rr_ov), 32'd1);
      check("bp_data", 32'(rr_od), 32'h55);
      check("bp_ready", 32'(rr_ird), 32'd0);
      tick();
    end
    rr_ordy = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_ird), 32'h4);
    tick();
    check("bp_no_gap_valid", 32'(rr_ov), 32'd1);
    check("bp_reload_data", 32'(rr_od), 32'h77);
    rr_iv = '0;
    tick();
    check("bp_drain_valid", 32'(rr_ov), 32'd0);
    check("bp_q_empty", 32'(q_rr.size()), 32'd0);
    // wrap-around with channels 0 and 3
    rr_id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rr_iv = 4'b1001;
    c0 = rr_cnt;
    for (int k = 0; k < 4; k++) q_rr.push_back((k % 2 == 0) ? beat(2'd3, 1'b0, 8'hA3) : beat(2'd0, 1'b0, 8'hA0));
    repeat (4) tick();
    rr_iv = '0;
    tick();
    check("wrap_count", 32'(rr_cnt - c0), 32'd4);
    check("wrap_q_empty", 32'(q_rr.size()), 32'd0);
    // fixed priority with channels 1 and 3
    fx_iv = 4'b1010;
    #1;
    check("fx_ready0", 32'(fx_ird), 32'h2);
    for (int k = 0; k < 3; k++) q_fx.push_back(beat(2'd1, 1'b0, 8'hB1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fx_ready_hold", 32'(fx_ird), 32'h2);
    end
    fx_iv = 4'b1000;
    #1;
    check("fx_ready_low", 32'(fx_ird), 32'h8);
    q_fx.push_back(beat(2'd3, 1'b0, 8'hB3));
    tick();
    fx_iv = '0;
    tick();
    check("fx_q_empty", 32'(q_fx.size()), 32'd0);
    check("fx_idle_valid", 32'(fx_ov), 32'd0);
    // packet lock: channel 0 three-beat packet, channel 1 single-beat packets
    pk_id = {8'h00, 8'h00, 8'hD1, 8'hC0};
    pk_il = 4'b0010;
    pk_iv = 4'b0011;
    #1;
    check("pk_ready_b1", 32'(pk_ird), 32'h1);
    q_pk.push_back(beat(2'd0, 1'b0, 8'hC0));
    tick();
    pk_iv = 4'b0010;
    #1;
    check("pk_gap_ready", 32'(pk_ird), 32'h0);
    tick();
    check("pk_gap_valid", 32'(pk_ov), 32'd0);
    pk_iv = 4'b0011;
    pk_id[7:0] = 8'hC1;
    #1;
    check("pk_ready_b2", 32'(pk_ird), 32'h1);
    q_pk.push_back(beat(2'd0, 1'b0, 8'hC1));
    tick();
    pk_id[7:0] = 8'hC2;
    pk_il[0] = 1'b1;
    #1;
    check("pk_ready_b3", 32'(pk_ird), 32'h1);
    q_pk.push_back(beat(2'd0, 1'b1, 8'hC2));
    tick();
    pk_id[7:0] = 8'hC3;
    #1;
    check("pk_ready_after_last", 32'(pk_ird), 32'h2);
    q_pk.push_back(beat(2'd1, 1'b1, 8'hD1));
    tick();
    pk_iv = '0;
    tick();
    check("pk_q_empty", 32'(q_pk.size()), 32'd0);
    check("pk_idle_valid", 32'(pk_ov), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
